// File: rtl/wb_stage_mq.sv
// ============================================================================
// Module   : wb_stage_mq
// Purpose  : MIPS writeback stage. Owns the M/W register, selects write-back
//            data, and shares the register-file port with a queue of MDU results.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_stage_mq #(
  parameter int                 DATA_W   = 32,
  parameter int                 REG_AW   = 5,
  parameter int                 LINK_REG = 31,
  parameter int                 MQ_DEPTH = 2,
  parameter int                 CNT_W    = 32,
  parameter logic [DATA_W-1:0]  RESET_PC = 'h00003000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_stall,
  input  logic                  w_flush,
  input  logic                  m_valid,
  input  logic [DATA_W-1:0]     m_pc,
  input  logic                  m_wr_en,
  input  logic [REG_AW-1:0]     m_wr_addr,
  input  logic [1:0]            m_wr_src,
  input  logic                  m_link_cond,
  input  logic [DATA_W-1:0]     m_rs_val,
  input  logic [DATA_W-1:0]     m_alu_res,
  input  logic [DATA_W-1:0]     m_imm,
  input  logic [DATA_W-1:0]     m_mem_word,
  input  logic [1:0]            m_byte_off,
  input  logic [2:0]            m_load_type,
  input  logic                  mdu_valid,
  input  logic [REG_AW-1:0]     mdu_addr,
  input  logic [DATA_W-1:0]     mdu_data,
  output logic                  mdu_ready,
  output logic                  rf_we,
  output logic [REG_AW-1:0]     rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  w_valid,
  output logic [DATA_W-1:0]     w_pc,
  output logic [2**REG_AW-1:0]  mdu_pend,
  output logic [CNT_W-1:0]      retire_cnt
);

  localparam int                c_nreg  = 2**REG_AW;
  localparam int                c_ptr_w = $clog2(MQ_DEPTH);
  localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w+1)'(MQ_DEPTH);
  localparam logic [REG_AW-1:0] c_link  = REG_AW'(LINK_REG);

  // W register
  logic                r_valid, r_wr_en, r_link_cond;
  logic [DATA_W-1:0]   r_pc, r_rs_val, r_alu_res, r_imm, r_mem_word;
  logic [REG_AW-1:0]   r_wr_addr;
  logic [1:0]          r_wr_src, r_byte_off;
  logic [2:0]          r_load_type;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_pc        <= RESET_PC;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_src    <= '0;
      r_link_cond <= 1'b0;
      r_rs_val    <= '0;
      r_alu_res   <= '0;
      r_imm       <= '0;
      r_mem_word  <= '0;
      r_byte_off  <= '0;
      r_load_type <= '0;
    end else if (w_flush) begin
      r_valid <= 1'b0;
    end else if (!w_stall) begin
      r_valid     <= m_valid;
      r_pc        <= m_pc;
      r_wr_en     <= m_wr_en;
      r_wr_addr   <= m_wr_addr;
      r_wr_src    <= m_wr_src;
      r_link_cond <= m_link_cond;
      r_rs_val    <= m_rs_val;
      r_alu_res   <= m_alu_res;
      r_imm       <= m_imm;
      r_mem_word  <= m_mem_word;
      r_byte_off  <= m_byte_off;
      r_load_type <= m_load_type;
    end
  end

  // Load extension and write-back source select
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load, w_pipe_data;

  assign w_byte = r_mem_word[{r_byte_off, 3'b000} +: 8];
  assign w_half = r_mem_word[{r_byte_off[1], 4'b0000} +: 16];

  always_comb begin
    case (r_load_type)
      3'd1:    w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'd2:    w_load = {{(DATA_W-8){1'b0}}, w_byte};
      3'd3:    w_load = {{(DATA_W-16){w_half[15]}}, w_half};
      3'd4:    w_load = {{(DATA_W-16){1'b0}}, w_half};
      default: w_load = r_mem_word;
    endcase
  end

  always_comb begin
    case (r_wr_src)
      2'd0:    w_pipe_data = r_alu_res;
      2'd1:    w_pipe_data = w_load;
      2'd2:    w_pipe_data = r_imm;
      default: w_pipe_data = r_pc + DATA_W'(8);
    endcase
  end

  // A not-taken conditional link resolves to r0, i.e. no write
  logic [REG_AW-1:0] w_dest;
  logic              w_pipe_wr;

  always_comb begin
    w_dest = '0;
    if (r_link_cond) begin
      if (r_rs_val[DATA_W-1]) w_dest = c_link;
    end else if (r_wr_en) begin
      w_dest = r_wr_addr;
    end
  end

  assign w_pipe_wr = r_valid && !w_stall && (w_dest != '0);

  // MDU result queue
  logic [REG_AW-1:0]  r_q_addr [MQ_DEPTH];
  logic [DATA_W-1:0]  r_q_data [MQ_DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr, r_wr_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_q_ne, w_push, w_pop;
  logic [MQ_DEPTH-1:0] w_occ;
  logic [c_nreg-1:0]  w_pend;

  assign w_q_ne    = (r_count != '0);
  assign mdu_ready = (r_count < c_depth);
  assign w_push    = mdu_valid && mdu_ready;
  assign w_pop     = !w_pipe_wr && w_q_ne;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= mdu_addr;
      r_q_data[r_wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Slot j is occupied when its distance from the read pointer is below count
  for (genvar j = 0; j < MQ_DEPTH; j++) begin : g_occ
    assign w_occ[j] = ((c_ptr_w+1)'(c_ptr_w'(j) - r_rd_ptr)) < r_count;
  end

  always_comb begin
    w_pend = '0;
    for (int j = 0; j < MQ_DEPTH; j++) begin
      if (w_occ[j]) w_pend[r_q_addr[j]] = 1'b1;
    end
    w_pend[0] = 1'b0;
  end

  assign mdu_pend = w_pend;

  // Register-file port arbitration: pipeline first, then queue head
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (w_pipe_wr) begin
      rf_we    = 1'b1;
      rf_waddr = w_dest;
      rf_wdata = w_pipe_data;
    end else if (w_q_ne) begin
      rf_we    = (r_q_addr[r_rd_ptr] != '0);
      rf_waddr = r_q_addr[r_rd_ptr];
      rf_wdata = r_q_data[r_rd_ptr];
    end
  end

  logic [CNT_W-1:0] r_retire;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_retire <= '0;
    end else if (r_valid && !w_stall && !w_flush) begin
      r_retire <= r_retire + CNT_W'(1);
    end
  end

  assign retire_cnt = r_retire;
  assign w_valid    = r_valid;
  assign w_pc       = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_mq.sv
// ============================================================================
// Module   : tb_wb_stage_mq
// Purpose  : Directed scoreboard bench for wb_stage_mq.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage_mq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        w_stall = 1'b0, w_flush = 1'b0;
  logic        m_valid = 1'b0, m_wr_en = 1'b0, m_link_cond = 1'b0;
  logic [31:0] m_pc = '0, m_rs_val = '0, m_alu_res = '0, m_imm = '0, m_mem_word = '0;
  logic [4:0]  m_wr_addr = '0;
  logic [1:0]  m_wr_src = '0, m_byte_off = '0;
  logic [2:0]  m_load_type = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_addr = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_ready, rf_we, w_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, w_pc, mdu_pend, retire_cnt;

  wb_stage_mq dut (
    .clk(clk), .reset(reset), .w_stall(w_stall), .w_flush(w_flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr),
    .m_wr_src(m_wr_src), .m_link_cond(m_link_cond), .m_rs_val(m_rs_val),
    .m_alu_res(m_alu_res), .m_imm(m_imm), .m_mem_word(m_mem_word),
    .m_byte_off(m_byte_off), .m_load_type(m_load_type),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .w_valid(w_valid), .w_pc(w_pc), .mdu_pend(mdu_pend), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t         sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic        mw_valid = 1'b0;
  logic [31:0] exp_ret = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Writes are sampled at the negedge, when the inputs for the coming edge are stable
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (rf_we === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("rf_unexpected_we", {63'd0, rf_we}, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.a});
        chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.d});
      end
    end
    chk("w_valid", {63'd0, w_valid}, {63'd0, mw_valid});
    chk("retire_cnt", {32'd0, retire_cnt}, {32'd0, exp_ret});
    if (!reset) begin
      mw_valid = 1'b0;
      exp_ret  = '0;
    end else begin
      if (mw_valid && !w_stall && !w_flush) exp_ret = exp_ret + 1;
      if (w_flush)       mw_valid = 1'b0;
      else if (!w_stall) mw_valid = m_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    m_valid = 1'b1; m_wr_en = 1'b1; m_wr_addr = a; m_wr_src = 2'd0;
    m_link_cond = 1'b0; m_alu_res = d; m_pc = pc;
  endtask

  task automatic set_load(input logic [4:0] a, input logic [2:0] lt, input logic [1:0] off);
    m_valid = 1'b1; m_wr_en = 1'b1; m_wr_addr = a; m_wr_src = 2'd1;
    m_link_cond = 1'b0; m_load_type = lt; m_byte_off = off; m_mem_word = 32'h80FF7F01;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_valid", {63'd0, w_valid}, 64'd0);
    chk("rst_w_pc", {32'd0, w_pc}, 64'h3000);
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_rf_wdata", {32'd0, rf_wdata}, 64'd0);
    chk("rst_mdu_ready", {63'd0, mdu_ready}, 64'd1);
    chk("rst_retire", {32'd0, retire_cnt}, 64'd0);
    chk("rst_pend", {32'd0, mdu_pend}, 64'd0);
    reset = 1'b1;

    // Load extension
    set_load(5'd3, 3'd1, 2'd3); sbq.push_back({5'd3, 32'hFFFFFF80}); tick();
    set_load(5'd4, 3'd4, 2'd2); sbq.push_back({5'd4, 32'h000080FF}); tick();
    set_load(5'd5, 3'd3, 2'd1); sbq.push_back({5'd5, 32'h00007F01}); tick();
    set_load(5'd6, 3'd7, 2'd0); sbq.push_back({5'd6, 32'h80FF7F01}); tick();
    set_load(5'd7, 3'd2, 2'd0); sbq.push_back({5'd7, 32'h00000001}); tick();

    // Conditional link taken / not taken, then pc+8 wrap
    m_valid = 1'b1; m_wr_en = 1'b1; m_wr_addr = 5'd31; m_wr_src = 2'd3;
    m_link_cond = 1'b1; m_rs_val = 32'hFFFFFFFF; m_pc = 32'h3010;
    sbq.push_back({5'd31, 32'h3018}); tick();
    m_rs_val = 32'h0; m_pc = 32'h3014; tick();
    chk("link_nt_we", {63'd0, rf_we}, 64'd0);
    chk("link_nt_pc", {32'd0, w_pc}, 64'h3014);
    m_link_cond = 1'b0; m_wr_addr = 5'd2; m_pc = 32'hFFFFFFFC;
    sbq.push_back({5'd2, 32'h4}); tick();
    m_valid = 1'b0; tick();

    // MDU queue fills while the pipeline owns the port
    set_alu(5'd10, 32'hA0, 32'h3100); sbq.push_back({5'd10, 32'hA0});
    mdu_valid = 1'b1; mdu_addr = 5'd8; mdu_data = 32'h88; tick();
    set_alu(5'd11, 32'hA1, 32'h3104); sbq.push_back({5'd11, 32'hA1});
    mdu_addr = 5'd9; mdu_data = 32'h99; tick();
    chk("mq_full_ready", {63'd0, mdu_ready}, 64'd0);
    chk("mq_full_pend", {32'd0, mdu_pend}, 64'h300);
    set_alu(5'd13, 32'hA3, 32'h3108); sbq.push_back({5'd13, 32'hA3});
    mdu_addr = 5'd12; mdu_data = 32'hCC; tick();
    chk("mq_full_ready2", {63'd0, mdu_ready}, 64'd0);
    m_valid = 1'b0; mdu_valid = 1'b0; sbq.push_back({5'd8, 32'h88}); tick();
    chk("mq_bubble_ready", {63'd0, mdu_ready}, 64'd0);
    chk("mq_bubble_pend", {32'd0, mdu_pend}, 64'h300);
    set_alu(5'd14, 32'hA4, 32'h310C); sbq.push_back({5'd14, 32'hA4}); tick();
    chk("mq_pop_ready", {63'd0, mdu_ready}, 64'd1);
    chk("mq_pop_pend", {32'd0, mdu_pend}, 64'h200);
    m_valid = 1'b0; sbq.push_back({5'd9, 32'h99}); tick();
    tick();
    chk("mq_empty_pend", {32'd0, mdu_pend}, 64'd0);
    chk("mq_empty_ready", {63'd0, mdu_ready}, 64'd1);
    tick();

    // Three-cycle stall; queue drains underneath it
    set_alu(5'd5, 32'h55, 32'h3200);
    mdu_valid = 1'b1; mdu_addr = 5'd20; mdu_data = 32'h2020; tick();
    w_stall = 1'b1; m_valid = 1'b0;
    mdu_addr = 5'd21; mdu_data = 32'h2121;
    sbq.push_back({5'd20, 32'h2020}); sbq.push_back({5'd21, 32'h2121});
    sbq.push_back({5'd5, 32'h55});
    tick();
    chk("stall_w_pc", {32'd0, w_pc}, 64'h3200);
    mdu_valid = 1'b0; tick();
    chk("stall_no_we", {63'd0, rf_we}, 64'd0);
    tick();
    w_stall = 1'b0; tick();
    tick();

    // Flush together with stall
    set_alu(5'd6, 32'h66, 32'h3300); tick();
    w_stall = 1'b1; w_flush = 1'b1; set_alu(5'd7, 32'h77, 32'h3304); tick();
    chk("flush_w_valid", {63'd0, w_valid}, 64'd0);
    w_stall = 1'b0; w_flush = 1'b0; m_valid = 1'b0; tick();
    tick();

    // Reset while the queue is full
    set_alu(5'd3, 32'h33, 32'h3400); sbq.push_back({5'd3, 32'h33});
    mdu_valid = 1'b1; mdu_addr = 5'd16; mdu_data = 32'h1616; tick();
    set_alu(5'd3, 32'h34, 32'h3404); sbq.push_back({5'd3, 32'h34});
    mdu_addr = 5'd17; mdu_data = 32'h1717; tick();
    chk("rstq_full_pend", {32'd0, mdu_pend}, 64'h30000);
    reset = 1'b0; mdu_valid = 1'b0; m_valid = 1'b0; tick();
    chk("rstq_pend", {32'd0, mdu_pend}, 64'd0);
    chk("rstq_ready", {63'd0, mdu_ready}, 64'd1);
    chk("rstq_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rstq_w_pc", {32'd0, w_pc}, 64'h3000);
    reset = 1'b1; tick();
    tick();
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
